// File: rtl/tile_input_buffer_if.sv
// -----------------------------------------------------------------------------
// tile_input_buffer_if
//
// Bundles the three channels of the tile input buffer so that the block and
// its environment connect through a single port:
//   instruction channel : instruction_valid / instruction_ready plus
//                         address_input, length_input (L), repeats_input (R)
//   memory read channel : mem_req_valid / mem_req_ready / mem_req_addr,
//                         mem_resp_valid / mem_resp_data (in order, no stall)
//   output beat channel : out_valid / out_ready / out_data / out_last
//   status              : busy, error
//
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// clk edge where valid and ready are both 1. Once valid is raised the payload
// stays stable until the transfer. mem_resp_valid has no ready and is taken
// on every edge where it is 1.
//
// Modports:
//   slave  - the tile input buffer itself
//   master - the environment (controller, memory and processor side)
// -----------------------------------------------------------------------------
interface tile_input_buffer_if #(
    parameter int DATA_WIDTH          = 8,
    parameter int N                   = 4,
    parameter int MAX_MATRIX_LENGTH   = 4096,
    parameter int MEMORY_ADDRESS_BITS = 64
);
    localparam int LEN_W  = $clog2(MAX_MATRIX_LENGTH + 1);
    localparam int REP_W  = $clog2(MAX_MATRIX_LENGTH / N + 1);
    localparam int WORD_W = N * DATA_WIDTH;

    logic                           instruction_valid;
    logic                           instruction_ready;
    logic [MEMORY_ADDRESS_BITS-1:0] address_input;
    logic [LEN_W-1:0]               length_input;
    logic [REP_W-1:0]               repeats_input;

    logic                           mem_req_valid;
    logic                           mem_req_ready;
    logic [MEMORY_ADDRESS_BITS-1:0] mem_req_addr;
    logic                           mem_resp_valid;
    logic [WORD_W-1:0]              mem_resp_data;

    logic                           out_valid;
    logic                           out_ready;
    logic [WORD_W-1:0]              out_data;
    logic                           out_last;

    logic                           busy;
    logic                           error;

    modport slave (
        input  instruction_valid, address_input, length_input, repeats_input,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        input  out_ready,
        output instruction_ready, mem_req_valid, mem_req_addr,
        output out_valid, out_data, out_last, busy, error
    );

    modport master (
        output instruction_valid, address_input, length_input, repeats_input,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        output out_ready,
        input  instruction_ready, mem_req_valid, mem_req_addr,
        input  out_valid, out_data, out_last, busy, error
    );
endinterface

// File: rtl/tile_input_buffer.sv
// -----------------------------------------------------------------------------
// tile_input_buffer
//
// Accepts an instruction (start address, L words per pass, R passes), fetches
// the L words from memory once into a local buffer and streams them to the
// processor R times, word 0..L-1 per pass, with out_last on word L-1.
// The first pass is served while words are still arriving; later passes are
// replayed from the buffer without touching memory.
//
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   bus (slave)     - instruction, memory read, output beat and status
//                     signals (see tile_input_buffer_if)
//
// An instruction with L==0, R==0 or L>BUFFER_DEPTH is consumed and dropped;
// L>BUFFER_DEPTH additionally sets the sticky error flag until reset.
// The FSM state is visible on bus.busy (1 exactly in RUN).
// -----------------------------------------------------------------------------
module tile_input_buffer #(
    parameter int DATA_WIDTH          = 8,
    parameter int N                   = 4,
    parameter int BUFFER_DEPTH        = 64,
    parameter int MAX_MATRIX_LENGTH   = 4096,
    parameter int MEMORY_ADDRESS_BITS = 64
) (
    input logic               clk,
    input logic               reset,
    tile_input_buffer_if.slave bus
);
    localparam int LEN_W  = $clog2(MAX_MATRIX_LENGTH + 1);
    localparam int REP_W  = $clog2(MAX_MATRIX_LENGTH / N + 1);
    localparam int IDX_W  = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int WORD_W = N * DATA_WIDTH;
    localparam int unsigned DEPTH_U = BUFFER_DEPTH;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [MEMORY_ADDRESS_BITS-1:0] base_addr_q;
    logic [LEN_W-1:0]               len_q;
    logic [REP_W-1:0]               rep_q;
    logic [LEN_W-1:0]               req_cnt_q;   // requests accepted by memory
    logic [LEN_W-1:0]               wr_cnt_q;    // words written into the buffer
    logic [LEN_W-1:0]               rd_ptr_q;    // next word to present
    logic [REP_W-1:0]               pass_cnt_q;  // completed passes
    logic                           error_q;

    // Not reset: stale words are never shown because out_valid requires
    // rd_ptr < wr_cnt, and wr_cnt restarts at 0 with every instruction.
    logic [WORD_W-1:0]              buffer_mem [BUFFER_DEPTH];

    logic len_too_long;
    logic instr_legal;
    logic instr_fire;
    logic req_valid;
    logic req_fire;
    logic resp_write;
    logic out_valid_w;
    logic out_last_w;
    logic out_fire;
    logic last_pass;

    always_comb begin
        len_too_long = 32'(bus.length_input) > DEPTH_U;
        instr_legal  = (bus.length_input != '0) && (bus.repeats_input != '0) && !len_too_long;
        instr_fire   = bus.instruction_valid && (state_q == IDLE);
        req_valid    = (state_q == RUN) && (req_cnt_q < len_q);
        req_fire     = req_valid && bus.mem_req_ready;
        // Responses past L (or arriving while idle, e.g. after a reset) are dropped.
        resp_write   = (state_q == RUN) && bus.mem_resp_valid && (wr_cnt_q < len_q);
        out_valid_w  = (state_q == RUN) && (rd_ptr_q < wr_cnt_q);
        out_last_w   = out_valid_w && (rd_ptr_q == len_q - LEN_W'(1));
        out_fire     = out_valid_w && bus.out_ready;
        last_pass    = (pass_cnt_q == rep_q - REP_W'(1));
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (instr_fire && instr_legal) state_d = RUN;
            RUN:  if (out_fire && out_last_w && last_pass) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters, latched instruction and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            base_addr_q <= '0;
            len_q       <= '0;
            rep_q       <= '0;
            req_cnt_q   <= '0;
            wr_cnt_q    <= '0;
            rd_ptr_q    <= '0;
            pass_cnt_q  <= '0;
            error_q     <= 1'b0;
        end else if (state_q == IDLE) begin
            if (instr_fire) begin
                if (len_too_long) begin
                    error_q <= 1'b1;
                end
                if (instr_legal) begin
                    base_addr_q <= bus.address_input;
                    len_q       <= bus.length_input;
                    rep_q       <= bus.repeats_input;
                    req_cnt_q   <= '0;
                    wr_cnt_q    <= '0;
                    rd_ptr_q    <= '0;
                    pass_cnt_q  <= '0;
                end
            end
        end else begin
            if (req_fire) begin
                req_cnt_q <= req_cnt_q + LEN_W'(1);
            end
            if (resp_write) begin
                wr_cnt_q <= wr_cnt_q + LEN_W'(1);
            end
            if (out_fire) begin
                if (out_last_w) begin
                    rd_ptr_q   <= '0;
                    pass_cnt_q <= pass_cnt_q + REP_W'(1);
                end else begin
                    rd_ptr_q <= rd_ptr_q + LEN_W'(1);
                end
            end
        end
    end

    // Word buffer: written in arrival order, read combinationally so a word
    // written on one edge is presentable in the following cycle.
    always_ff @(posedge clk) begin
        if (!reset && resp_write) begin
            buffer_mem[wr_cnt_q[IDX_W-1:0]] <= bus.mem_resp_data;
        end
    end

    assign bus.instruction_ready = (state_q == IDLE);
    assign bus.busy              = (state_q == RUN);
    assign bus.error             = error_q;
    assign bus.mem_req_valid     = req_valid;
    assign bus.mem_req_addr      = base_addr_q + MEMORY_ADDRESS_BITS'(req_cnt_q);
    assign bus.out_valid         = out_valid_w;
    assign bus.out_last          = out_last_w;
    assign bus.out_data          = buffer_mem[rd_ptr_q[IDX_W-1:0]];

endmodule

// File: tb/tb_tile_input_buffer.sv
// -----------------------------------------------------------------------------
// tb_tile_input_buffer
//
// Drives instructions into tile_input_buffer, models a fixed-latency in-order
// memory, and checks every request address and output beat against a queue
// built from the instruction alone: for each pass, words addr+0 .. addr+L-1,
// last flag on word L-1. A table of directed instructions runs first, then a
// mid-operation reset sequence, then randomized instructions.
// -----------------------------------------------------------------------------
module tb_tile_input_buffer;
    localparam int DATA_WIDTH          = 8;
    localparam int N                   = 4;
    localparam int BUFFER_DEPTH        = 64;
    localparam int MAX_MATRIX_LENGTH   = 4096;
    localparam int MEMORY_ADDRESS_BITS = 64;
    localparam int LEN_W  = $clog2(MAX_MATRIX_LENGTH + 1);
    localparam int REP_W  = $clog2(MAX_MATRIX_LENGTH / N + 1);
    localparam int WORD_W = N * DATA_WIDTH;
    localparam int AW     = MEMORY_ADDRESS_BITS;
    localparam int W      = WORD_W + 1;   // {data, last}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tile_input_buffer_if #(
        .DATA_WIDTH(DATA_WIDTH), .N(N),
        .MAX_MATRIX_LENGTH(MAX_MATRIX_LENGTH), .MEMORY_ADDRESS_BITS(MEMORY_ADDRESS_BITS)
    ) bus ();

    tile_input_buffer #(
        .DATA_WIDTH(DATA_WIDTH), .N(N), .BUFFER_DEPTH(BUFFER_DEPTH),
        .MAX_MATRIX_LENGTH(MAX_MATRIX_LENGTH), .MEMORY_ADDRESS_BITS(MEMORY_ADDRESS_BITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    typedef struct {
        int             due;
        logic [AW-1:0]  addr;
    } pend_t;

    typedef struct {
        int             len;
        int             reps;
        logic [AW-1:0]  addr;
        int             lat;
        int             mode;
        bit             rr;
        int             exp_beats;
        int             exp_reqs;
        bit             exp_err;
    } vec_t;

    logic [W-1:0]  exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    pend_t         pend_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int lat         = 1;
    int out_mode    = 0;   // 0: always ready, 1: toggle, 2: random
    bit req_rand    = 1'b0;
    int beats, reqs;
    int first_resp_cyc, first_valid_cyc, last_beat_cyc;
    bit stalled     = 1'b0;
    logic [W-1:0] held;
    logic [31:0] seed;
    bit model_err;

    vec_t vecs[9];

    function automatic logic [WORD_W-1:0] mem_word(input logic [AW-1:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ seed;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event not allowed here (cycle %0d)", name, cyc);
    endtask

    // One clock: score the transfers the coming edge performs, advance to the
    // falling edge, then drive memory/processor inputs for the next edge.
    task automatic tick();
        pend_t p;
        if (!reset) begin
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                reqs++;
                if (exp_addr_q.size() == 0) fail_now("extra_request");
                else check("req_addr", bus.mem_req_addr, exp_addr_q.pop_front());
                pend_q.push_back('{cyc + lat, bus.mem_req_addr});
            end
            if (bus.out_valid && bus.out_ready) begin
                beats++;
                last_beat_cyc = cyc;
                if (exp_q.size() == 0) fail_now("extra_beat");
                else check("beat", {bus.out_data, bus.out_last}, exp_q.pop_front());
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = {bus.out_data, bus.out_last};
        end else begin
            stalled = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        bus.mem_req_ready = req_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        case (out_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'(cyc % 2);
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            p = pend_q.pop_front();
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = mem_word(p.addr);
            if (first_resp_cyc < 0) first_resp_cyc = cyc;
        end else begin
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = $urandom;
        end
        if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (stalled) check("stall_hold", {bus.out_valid, bus.out_data, bus.out_last}, {1'b1, held});
        if (!bus.busy) check("idle_quiet", {bus.out_valid, bus.mem_req_valid}, 2'b00);
    endtask

    task automatic check_reset_values();
        check("reset_outputs",
              {bus.instruction_ready, bus.busy, bus.mem_req_valid, bus.out_valid, bus.out_last, bus.error},
              6'b100000);
    endtask

    // Builds the expectation from the instruction and presents it for one edge.
    task automatic start_instr(input int len, input int reps, input logic [AW-1:0] addr,
                               input int l_lat, input int mode, input bit rr, output bit legal);
        legal    = (len > 0) && (reps > 0) && (len <= BUFFER_DEPTH);
        lat      = l_lat;
        out_mode = mode;
        req_rand = rr;
        if (legal) begin
            for (int r = 0; r < reps; r++)
                for (int k = 0; k < len; k++)
                    exp_q.push_back({mem_word(addr + AW'(k)), (k == len - 1)});
            for (int k = 0; k < len; k++) exp_addr_q.push_back(addr + AW'(k));
        end
        beats = 0; reqs = 0;
        first_resp_cyc = -1; first_valid_cyc = -1; last_beat_cyc = -1;
        check("ready_before_instr", bus.instruction_ready, 1'b1);
        bus.instruction_valid = 1'b1;
        bus.address_input     = addr;
        bus.length_input      = LEN_W'(len);
        bus.repeats_input     = REP_W'(reps);
        tick();
        bus.instruction_valid = 1'b0;
        bus.address_input     = {$urandom, $urandom};
        bus.length_input      = LEN_W'($urandom);
        bus.repeats_input     = REP_W'($urandom);
        check("busy_after_instr", bus.busy, legal);
    endtask

    task automatic run_instr(input int len, input int reps, input logic [AW-1:0] addr,
                             input int l_lat, input int mode, input bit rr,
                             input int exp_beats, input int exp_reqs, input bit exp_err);
        bit legal;
        int n;
        start_instr(len, reps, addr, l_lat, mode, rr, legal);
        n = 0;
        while (bus.busy && n < 20000) begin
            tick();
            n++;
        end
        if (bus.busy) begin
            fail_now("timeout_busy");
        end else if (legal) begin
            check("ready_after_last_beat", cyc, last_beat_cyc + 1);
            check("first_valid_latency", first_valid_cyc, first_resp_cyc + 1);
        end else begin
            repeat (8) tick();
        end
        check("beat_count", beats, exp_beats);
        check("req_count", reqs, exp_reqs);
        check("beats_left", exp_q.size(), 0);
        check("reqs_left", exp_addr_q.size(), 0);
        check("error_flag", bus.error, exp_err);
        check("ready_at_end", bus.instruction_ready, 1'b1);
        exp_q.delete();
        exp_addr_q.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit legal;
        int n, len, reps;
        logic [AW-1:0] addr;

        seed = $urandom;
        reset = 1'b1;
        bus.instruction_valid = 1'b0;
        bus.address_input     = '0;
        bus.length_input      = '0;
        bus.repeats_input     = '0;
        bus.mem_req_ready     = 1'b1;
        bus.mem_resp_valid    = 1'b0;
        bus.mem_resp_data     = '0;
        bus.out_ready         = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check_reset_values();

        //         len reps addr                        lat mode rr beats reqs err
        vecs[0] = '{3,  2,  64'h100,                     1,  0,  0,  6,    3,  0};
        vecs[1] = '{4,  1,  64'h2000,                    1,  1,  1,  4,    4,  0};
        vecs[2] = '{64, 3,  64'h5000,                    5,  0,  0,  192,  64, 0};
        vecs[3] = '{1,  1,  64'h0000_0001_0000_0040,     2,  2,  1,  1,    1,  0};
        vecs[4] = '{3,  2,  64'hFFFF_FFFF_FFFF_FFFF,     3,  2,  1,  6,    3,  0};
        vecs[5] = '{0,  5,  64'h300,                     1,  0,  0,  0,    0,  0};
        vecs[6] = '{65, 1,  64'h400,                     1,  0,  0,  0,    0,  1};
        vecs[7] = '{5,  0,  64'h500,                     1,  0,  0,  0,    0,  1};
        vecs[8] = '{7,  2,  64'h600,                     4,  2,  1,  14,   7,  1};
        for (int i = 0; i < 9; i++)
            run_instr(vecs[i].len, vecs[i].reps, vecs[i].addr, vecs[i].lat, vecs[i].mode,
                      vecs[i].rr, vecs[i].exp_beats, vecs[i].exp_reqs, vecs[i].exp_err);

        // Reset in the middle of pass 0 with two responses still in flight.
        start_instr(8, 2, 64'h7000, 3, 0, 0, legal);
        n = 0;
        while (!(reqs == 8 && pend_q.size() == 2) && n < 200) begin
            tick();
            n++;
        end
        check("midrun_two_outstanding", pend_q.size(), 2);
        check("midrun_busy", bus.busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_values();
        exp_q.delete();
        exp_addr_q.delete();
        n = 0;
        while (pend_q.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        check("late_resp_ignored",
              {bus.out_valid, bus.mem_req_valid, bus.busy, bus.instruction_ready}, 4'b0001);
        run_instr(2, 1, 64'h7100, 1, 0, 0, 2, 2, 0);

        // Randomized instructions checked against the instruction-level model.
        model_err = 1'b0;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 9))
                0:       len = 0;
                1:       len = BUFFER_DEPTH + 1;
                2:       len = BUFFER_DEPTH;
                default: len = $urandom_range(1, 24);
            endcase
            reps = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            addr = {$urandom, $urandom};
            if (len > BUFFER_DEPTH) model_err = 1'b1;
            legal = (len > 0) && (reps > 0) && (len <= BUFFER_DEPTH);
            run_instr(len, reps, addr, $urandom_range(1, 6), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)),
                      legal ? len * reps : 0, legal ? len : 0, model_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
